// File: rtl/pmem_arbiter_if.sv
// rtl/pmem_arbiter_if.sv - fetch, load/store and memory port bundle for pmem_arbiter.
// slave = arbiter view; master = requester/memory environment view.
interface pmem_arbiter_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_resp_valid;
  logic        ifu_resp_ready;
  logic [31:0] ifu_resp_data;

  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_req_addr;
  logic        lsu_req_wen;
  logic [31:0] lsu_req_wdata;
  logic [3:0]  lsu_req_wmask;
  logic        lsu_resp_valid;
  logic        lsu_resp_ready;
  logic [31:0] lsu_resp_data;

  logic        mem_ren;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        mem_wen;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;

  modport slave (
    input  ifu_req_valid, ifu_req_addr, ifu_resp_ready,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_data,
    input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask, lsu_resp_ready,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_data,
    input  mem_rdata,
    output mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask
  );

  modport master (
    output ifu_req_valid, ifu_req_addr, ifu_resp_ready,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_data,
    output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask, lsu_resp_ready,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_data,
    output mem_rdata,
    input  mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - single-outstanding IFU/LSU arbiter onto one memory port.
// Define PMEM_ARB_RR_EN for round-robin grant; default is fixed LSU priority.
module pmem_arbiter #(
  parameter int unsigned LATENCY = 1
) (
  input  logic          clock,
  input  logic          reset,
  pmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t      state;
  state_t      state_nxt;
  logic        owner_lsu;
  logic        wen_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wmask_q;
  logic [3:0]  cnt_q;
  logic [31:0] resp_data_q;
  logic        grant_lsu;
  logic        ifu_hs;
  logic        lsu_hs;
  logic        strobe;

`ifdef PMEM_ARB_RR_EN
  logic last_lsu;

  // On a tie the requester that did not win last time gets the grant.
  assign grant_lsu = bus.lsu_req_valid & (~bus.ifu_req_valid | ~last_lsu);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_lsu <= 1'b0;
    end else if (ifu_hs || lsu_hs) begin
      last_lsu <= lsu_hs;
    end
  end
`else
  assign grant_lsu = bus.lsu_req_valid;
`endif

  assign lsu_hs = reset & (state == IDLE) & grant_lsu;
  assign ifu_hs = reset & (state == IDLE) & bus.ifu_req_valid & ~grant_lsu;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    strobe             = 1'b0;
    bus.ifu_req_ready  = 1'b0;
    bus.lsu_req_ready  = 1'b0;
    bus.ifu_resp_valid = 1'b0;
    bus.lsu_resp_valid = 1'b0;
    bus.mem_ren        = 1'b0;
    bus.mem_wen        = 1'b0;
    // Outputs are gated by reset so they drop the instant it is asserted.
    if (reset) begin
      case (state)
        IDLE: begin
          bus.ifu_req_ready = ifu_hs;
          bus.lsu_req_ready = lsu_hs;
          if (ifu_hs || lsu_hs) begin
            state_nxt = WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            strobe      = 1'b1;
            bus.mem_ren = ~wen_q;
            bus.mem_wen = wen_q;
            state_nxt   = RESP;
          end
        end
        RESP: begin
          bus.ifu_resp_valid = ~owner_lsu;
          bus.lsu_resp_valid = owner_lsu;
          if (owner_lsu ? bus.lsu_resp_ready : bus.ifu_resp_ready) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner_lsu   <= 1'b0;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      cnt_q       <= '0;
      resp_data_q <= '0;
    end else begin
      if (ifu_hs || lsu_hs) begin
        owner_lsu <= lsu_hs;
        addr_q    <= lsu_hs ? bus.lsu_req_addr : bus.ifu_req_addr;
        wen_q     <= lsu_hs & bus.lsu_req_wen;
        wdata_q   <= lsu_hs ? bus.lsu_req_wdata : 32'd0;
        wmask_q   <= lsu_hs ? bus.lsu_req_wmask : 4'd0;
        cnt_q     <= CNT_LOAD;
      end else if (state == WAIT && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      // Stores complete with a zero response word.
      if (strobe) begin
        resp_data_q <= wen_q ? 32'd0 : bus.mem_rdata;
      end
    end
  end

  assign bus.mem_raddr     = addr_q;
  assign bus.mem_waddr     = addr_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_wmask     = wmask_q;
  assign bus.ifu_resp_data = resp_data_q;
  assign bus.lsu_resp_data = resp_data_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb/tb_pmem_arbiter.sv - directed self-checking bench for pmem_arbiter.
// Three instances cover LATENCY 1, 3 and 4; they share clock and reset.
module tb_pmem_arbiter;
  logic clock;
  logic reset;
  int   checks;
  int   errors;
  logic [3:0] g;
  logic [3:0] g_exp;
  int   gcyc[4];
  int   ngrant;

  pmem_arbiter_if if1();
  pmem_arbiter_if if3();
  pmem_arbiter_if if4();

  pmem_arbiter #(.LATENCY(1)) u1 (.clock(clock), .reset(reset), .bus(if1));
  pmem_arbiter #(.LATENCY(3)) u3 (.clock(clock), .reset(reset), .bus(if3));
  pmem_arbiter #(.LATENCY(4)) u4 (.clock(clock), .reset(reset), .bus(if4));

  assign if1.mem_rdata = (if1.mem_raddr == 32'h8000_0000) ? 32'h0000_0413 : ~if1.mem_raddr;
  assign if3.mem_rdata = ~if3.mem_raddr;
  assign if4.mem_rdata = ~if4.mem_raddr;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ngrant = 0;
    g = '0;
    reset = 1'b0;
    if1.ifu_req_valid = 1'b0; if1.ifu_req_addr = '0; if1.ifu_resp_ready = 1'b0;
    if1.lsu_req_valid = 1'b0; if1.lsu_req_addr = '0; if1.lsu_req_wen = 1'b0;
    if1.lsu_req_wdata = '0;   if1.lsu_req_wmask = '0; if1.lsu_resp_ready = 1'b0;
    if3.ifu_req_valid = 1'b0; if3.ifu_req_addr = '0; if3.ifu_resp_ready = 1'b0;
    if3.lsu_req_valid = 1'b0; if3.lsu_req_addr = '0; if3.lsu_req_wen = 1'b0;
    if3.lsu_req_wdata = '0;   if3.lsu_req_wmask = '0; if3.lsu_resp_ready = 1'b0;
    if4.ifu_req_valid = 1'b0; if4.ifu_req_addr = '0; if4.ifu_resp_ready = 1'b0;
    if4.lsu_req_valid = 1'b0; if4.lsu_req_addr = '0; if4.lsu_req_wen = 1'b0;
    if4.lsu_req_wdata = '0;   if4.lsu_req_wmask = '0; if4.lsu_resp_ready = 1'b0;

    // Reset state: requests pending during reset must not be accepted.
    if1.ifu_req_valid = 1'b1;
    if1.lsu_req_valid = 1'b1;
    @(negedge clock); #1;
    check1("rst_ifu_req_ready", if1.ifu_req_ready, 1'b0);
    check1("rst_lsu_req_ready", if1.lsu_req_ready, 1'b0);
    check1("rst_ifu_resp_valid", if1.ifu_resp_valid, 1'b0);
    check1("rst_lsu_resp_valid", if1.lsu_resp_valid, 1'b0);
    check1("rst_mem_ren", if1.mem_ren, 1'b0);
    check1("rst_mem_wen", if1.mem_wen, 1'b0);
    check32("rst_mem_raddr", if1.mem_raddr, 32'h0);
    @(negedge clock);
    if1.ifu_req_valid = 1'b0;
    if1.lsu_req_valid = 1'b0;
    reset = 1'b1;

    // Both requesters always valid, responses taken at once: four grants.
    @(negedge clock);
    if1.ifu_resp_ready = 1'b1; if1.lsu_resp_ready = 1'b1;
    if1.ifu_req_addr = 32'h8000_0004; if1.lsu_req_addr = 32'h8000_2000;
    if1.ifu_req_valid = 1'b1; if1.lsu_req_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      check1("c_both_ready", if1.ifu_req_ready & if1.lsu_req_ready, 1'b0);
      if (ngrant < 4 && (if1.ifu_req_ready || if1.lsu_req_ready)) begin
        g[ngrant] = if1.lsu_req_ready;
        gcyc[ngrant] = c;
        ngrant++;
      end
      if (ngrant == 4) begin
        if1.ifu_req_valid = 1'b0;
        if1.lsu_req_valid = 1'b0;
        break;
      end
      @(negedge clock);
    end
`ifdef PMEM_ARB_RR_EN
    g_exp = 4'b0101;
`else
    g_exp = 4'b1111;
`endif
    check32("c_grant_count", 32'(ngrant), 32'd4);
    check32("c_grant_order", 32'(g), 32'(g_exp));
    check32("c_spacing_01", 32'(gcyc[1] - gcyc[0]), 32'd3);
    check32("c_spacing_23", 32'(gcyc[3] - gcyc[2]), 32'd3);
    repeat (4) @(negedge clock);
    if1.ifu_resp_ready = 1'b0; if1.lsu_resp_ready = 1'b0;
    #1;
    check1("c_drained_ifu", if1.ifu_resp_valid, 1'b0);
    check1("c_drained_lsu", if1.lsu_resp_valid, 1'b0);

    // LATENCY=1 fetch.
    @(negedge clock);
    if1.ifu_req_valid = 1'b1; if1.ifu_req_addr = 32'h8000_0000; #1;
    check1("a_ifu_req_ready", if1.ifu_req_ready, 1'b1);
    check1("a_lsu_req_ready", if1.lsu_req_ready, 1'b0);
    @(negedge clock);
    if1.ifu_req_valid = 1'b0; #1;
    check1("a_mem_ren", if1.mem_ren, 1'b1);
    check32("a_mem_raddr", if1.mem_raddr, 32'h8000_0000);
    check1("a_mem_wen", if1.mem_wen, 1'b0);
    check1("a_resp_early", if1.ifu_resp_valid, 1'b0);
    @(negedge clock);
    if1.ifu_resp_ready = 1'b1; #1;
    check1("a_resp_valid", if1.ifu_resp_valid, 1'b1);
    check32("a_resp_data", if1.ifu_resp_data, 32'h0000_0413);
    check1("a_lsu_resp_valid", if1.lsu_resp_valid, 1'b0);
    check1("a_mem_ren_single", if1.mem_ren, 1'b0);
    @(negedge clock);
    if1.ifu_resp_ready = 1'b0; #1;
    check1("a_resp_done", if1.ifu_resp_valid, 1'b0);

    // LATENCY=1 store.
    @(negedge clock);
    if1.lsu_req_valid = 1'b1; if1.lsu_req_addr = 32'h8000_1000; if1.lsu_req_wen = 1'b1;
    if1.lsu_req_wdata = 32'hDEAD_BEEF; if1.lsu_req_wmask = 4'h3; #1;
    check1("b_lsu_req_ready", if1.lsu_req_ready, 1'b1);
    check1("b_ifu_req_ready", if1.ifu_req_ready, 1'b0);
    @(negedge clock);
    if1.lsu_req_valid = 1'b0; #1;
    check1("b_mem_wen", if1.mem_wen, 1'b1);
    check1("b_mem_ren", if1.mem_ren, 1'b0);
    check32("b_mem_waddr", if1.mem_waddr, 32'h8000_1000);
    check32("b_mem_wdata", if1.mem_wdata, 32'hDEAD_BEEF);
    check32("b_mem_wmask", 32'(if1.mem_wmask), 32'h3);
    @(negedge clock);
    if1.lsu_resp_ready = 1'b1; #1;
    check1("b_mem_wen_single", if1.mem_wen, 1'b0);
    check1("b_mem_ren_after", if1.mem_ren, 1'b0);
    check1("b_lsu_resp_valid", if1.lsu_resp_valid, 1'b1);
    check32("b_lsu_resp_data", if1.lsu_resp_data, 32'h0);
    check1("b_ifu_resp_valid", if1.ifu_resp_valid, 1'b0);
    @(negedge clock);
    if1.lsu_resp_ready = 1'b0; if1.lsu_req_wen = 1'b0; #1;
    check1("b_resp_done", if1.lsu_resp_valid, 1'b0);

    // LATENCY=3 fetch with a five-cycle response stall; request held valid.
    @(negedge clock);
    if3.ifu_req_valid = 1'b1; if3.ifu_req_addr = 32'h8000_0010; #1;
    check1("d_ifu_req_ready", if3.ifu_req_ready, 1'b1);
    @(negedge clock); #1;
    check1("d_wait1_ren", if3.mem_ren, 1'b0);
    check1("d_wait1_ready", if3.ifu_req_ready, 1'b0);
    @(negedge clock); #1;
    check1("d_wait2_ren", if3.mem_ren, 1'b0);
    @(negedge clock); #1;
    check1("d_strobe_ren", if3.mem_ren, 1'b1);
    check32("d_strobe_raddr", if3.mem_raddr, 32'h8000_0010);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock); #1;
      check1("d_stall_valid", if3.ifu_resp_valid, 1'b1);
      check32("d_stall_data", if3.ifu_resp_data, 32'h7FFF_FFEF);
      check1("d_stall_req_ready", if3.ifu_req_ready, 1'b0);
      check1("d_stall_ren", if3.mem_ren, 1'b0);
    end
    @(negedge clock);
    if3.ifu_resp_ready = 1'b1; #1;
    check1("d_release_valid", if3.ifu_resp_valid, 1'b1);
    check1("d_release_req_ready", if3.ifu_req_ready, 1'b0);
    @(negedge clock);
    if3.ifu_resp_ready = 1'b0; #1;
    check1("d_after_valid", if3.ifu_resp_valid, 1'b0);
    check1("d_after_req_ready", if3.ifu_req_ready, 1'b1);
    if3.ifu_req_valid = 1'b0;

    // LATENCY=4 store abandoned by reset during WAIT.
    @(negedge clock);
    if4.lsu_req_valid = 1'b1; if4.lsu_req_addr = 32'h8000_3000; if4.lsu_req_wen = 1'b1;
    if4.lsu_req_wdata = 32'h1234_5678; if4.lsu_req_wmask = 4'hF; #1;
    check1("e_lsu_req_ready", if4.lsu_req_ready, 1'b1);
    @(negedge clock);
    if4.lsu_req_valid = 1'b0; #1;
    check1("e_wait1_wen", if4.mem_wen, 1'b0);
    @(negedge clock); #1;
    check1("e_wait2_wen", if4.mem_wen, 1'b0);
    reset = 1'b0;
    if4.lsu_req_valid = 1'b1; #1;
    check1("e_rst_lsu_req_ready", if4.lsu_req_ready, 1'b0);
    check1("e_rst_wen", if4.mem_wen, 1'b0);
    check1("e_rst_resp_valid", if4.lsu_resp_valid, 1'b0);
    check32("e_rst_waddr", if4.mem_waddr, 32'h0);
    check32("e_rst_wdata", if4.mem_wdata, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock); #1;
      check1("e_hold_wen", if4.mem_wen, 1'b0);
    end
    @(negedge clock);
    reset = 1'b1;
    if4.lsu_req_valid = 1'b0; if4.lsu_req_wen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check1("e_post_wen", if4.mem_wen, 1'b0);
      check1("e_post_ren", if4.mem_ren, 1'b0);
      check1("e_post_resp_valid", if4.lsu_resp_valid, 1'b0);
      @(negedge clock);
    end
    if4.lsu_req_valid = 1'b1; if4.ifu_req_valid = 1'b1; #1;
    check1("e_idle_lsu_wins", if4.lsu_req_ready, 1'b1);
    check1("e_idle_ifu_waits", if4.ifu_req_ready, 1'b0);
    if4.lsu_req_valid = 1'b0; if4.ifu_req_valid = 1'b0;
    @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
